vga_scaler_fetch: RTL and testbench

Parametrised nearest-neighbour scaler and frame-buffer fetch stage between the VGA timing controller and the capture BRAM. It maps every visible output pixel of a DST_W×DST_H raster onto a SRC_W×SRC_H source frame using incremental (DDA) accumulators, so no multipliers or dividers are needed. It drives the BRAM read address, absorbs a configurable BRAM read latency, and emits colour plus sync signals delayed so that all outputs stay aligned. A pixel-format mode selects greyscale or RGB332 expansion.

---
 rtl/vga_scaler_fetch.sv | 155 +++++++++++++++
 tb/tb_vga_scaler_fetch.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/vga_scaler_fetch.sv
// Nearest-neighbour scaler and frame-buffer fetch between VGA timing and capture BRAM.
// DDA accumulators map output pixels to source addresses; syncs are delayed to stay aligned with colour.
module vga_scaler_fetch #(
  parameter int unsigned SRC_W    = 576,
  parameter int unsigned SRC_H    = 378,
  parameter int unsigned DST_W    = 800,
  parameter int unsigned DST_H    = 600,
  parameter int unsigned ADDR_W   = 18,
  parameter int unsigned BRAM_LAT = 1,
  parameter logic        SYNC_POL = 1'b0,
  parameter int unsigned MODE     = 0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              ENABLE,
  input  logic              IN_HS,
  input  logic              IN_VS,
  input  logic              IN_VISIBLE,
  output logic [ADDR_W-1:0] BRAM_ADDR,
  input  logic [7:0]        BRAM_DOUT,
  output logic [7:0]        VGA_R,
  output logic [7:0]        VGA_G,
  output logic [7:0]        VGA_B,
  output logic              VGA_HS,
  output logic              VGA_VS
);

  localparam int unsigned LAT = BRAM_LAT + 2;
  localparam int unsigned XW  = $clog2(DST_W + SRC_W + 1);
  localparam int unsigned YW  = $clog2(DST_H + SRC_H + 1);

  logic [XW-1:0]     acc_x_q, acc_x_d, acc_x_inc;
  logic [YW-1:0]     acc_y_q, acc_y_d, acc_y_inc;
  logic [ADDR_W-1:0] src_x_q, src_x_d;
  logic [ADDR_W-1:0] src_y_q, src_y_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              vis_q, vis_d;
  logic [LAT-1:0]    hs_pipe_q, hs_pipe_d;
  logic [LAT-1:0]    vs_pipe_q, vs_pipe_d;
  logic [LAT-1:0]    act_pipe_q, act_pipe_d;
  logic [7:0]        r_q, r_d, g_q, g_d, b_q, b_d;
  logic [7:0]        pix_r, pix_g, pix_b;
  logic              frame_start, line_end, pix_en;

  assign frame_start = (IN_VS == SYNC_POL);
  assign line_end    = vis_q & ~IN_VISIBLE;
  assign pix_en      = IN_VISIBLE & ENABLE;
  assign acc_x_inc   = acc_x_q + XW'(SRC_W);
  assign acc_y_inc   = acc_y_q + YW'(SRC_H);

  // Horizontal/vertical DDA and address generation; frame start overrides line end.
  always_comb begin
    acc_x_d    = acc_x_q;
    acc_y_d    = acc_y_q;
    src_x_d    = src_x_q;
    src_y_d    = src_y_q;
    row_base_d = row_base_q;
    addr_d     = '0;
    vis_d      = IN_VISIBLE;
    if (pix_en) addr_d = row_base_q + src_x_q;
    if (!ENABLE || frame_start) begin
      acc_x_d    = '0;
      acc_y_d    = '0;
      src_x_d    = '0;
      src_y_d    = '0;
      row_base_d = '0;
    end else if (line_end) begin
      acc_x_d = '0;
      src_x_d = '0;
      acc_y_d = acc_y_inc;
      if (acc_y_inc >= YW'(DST_H)) begin
        acc_y_d = acc_y_inc - YW'(DST_H);
        if (src_y_q != ADDR_W'(SRC_H - 1)) begin
          src_y_d    = src_y_q + ADDR_W'(1);
          row_base_d = row_base_q + ADDR_W'(SRC_W);
        end
      end
    end else if (pix_en && (src_x_q != ADDR_W'(SRC_W - 1))) begin
      acc_x_d = acc_x_inc;
      if (acc_x_inc >= XW'(DST_W)) begin
        acc_x_d = acc_x_inc - XW'(DST_W);
        src_x_d = src_x_q + ADDR_W'(1);
      end
    end
  end

  // Pixel format expansion of the returned BRAM byte.
  always_comb begin
    if (MODE == 1) begin
      pix_r = {BRAM_DOUT[7:5], BRAM_DOUT[7:5], BRAM_DOUT[7:6]};
      pix_g = {BRAM_DOUT[4:2], BRAM_DOUT[4:2], BRAM_DOUT[4:3]};
      pix_b = {4{BRAM_DOUT[1:0]}};
    end else begin
      pix_r = BRAM_DOUT;
      pix_g = BRAM_DOUT;
      pix_b = BRAM_DOUT;
    end
  end

  // Sync/active delay lines; colour is gated by the active flag one stage before the output.
  always_comb begin
    hs_pipe_d  = {hs_pipe_q[LAT-2:0], IN_HS};
    vs_pipe_d  = {vs_pipe_q[LAT-2:0], IN_VS};
    act_pipe_d = {act_pipe_q[LAT-2:0], pix_en};
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (act_pipe_q[LAT-2]) begin
      r_d = pix_r;
      g_d = pix_g;
      b_d = pix_b;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      acc_x_q    <= '0;
      acc_y_q    <= '0;
      src_x_q    <= '0;
      src_y_q    <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
      vis_q      <= 1'b0;
      hs_pipe_q  <= {LAT{~SYNC_POL}};
      vs_pipe_q  <= {LAT{~SYNC_POL}};
      act_pipe_q <= '0;
      r_q        <= '0;
      g_q        <= '0;
      b_q        <= '0;
    end else begin
      acc_x_q    <= acc_x_d;
      acc_y_q    <= acc_y_d;
      src_x_q    <= src_x_d;
      src_y_q    <= src_y_d;
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
      vis_q      <= vis_d;
      hs_pipe_q  <= hs_pipe_d;
      vs_pipe_q  <= vs_pipe_d;
      act_pipe_q <= act_pipe_d;
      r_q        <= r_d;
      g_q        <= g_d;
      b_q        <= b_d;
    end
  end

  assign BRAM_ADDR = addr_q;
  assign VGA_R     = r_q;
  assign VGA_G     = g_q;
  assign VGA_B     = b_q;
  assign VGA_HS    = hs_pipe_q[LAT-1];
  assign VGA_VS    = vs_pipe_q[LAT-1];

endmodule

// File: tb/tb_vga_scaler_fetch.sv
// Directed bench: three scaler configurations share one sync stream; expected addresses come
// from hand-computed tables, colour/sync expectations from the recorded stimulus history.
module tb_vga_scaler_fetch;

  localparam int HN = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, in_hs = 1'b1, in_vs = 1'b1, in_vis = 1'b0, en_c = 1'b1;
  logic [7:0] a_addr, b_addr, c_addr;
  logic [7:0] a_dout, b_dout, c_dout;
  logic [7:0] b_p0, b_p1;
  logic [7:0] a_r, a_g, a_b, b_r, b_g, b_b, c_r, c_g, c_b;
  logic       a_hs, a_vs, b_hs, b_vs, c_hs, c_vs;

  // a: 4x3 -> 8x6 grey, latency 1
  vga_scaler_fetch #(.SRC_W(4), .SRC_H(3), .DST_W(8), .DST_H(6), .ADDR_W(8), .BRAM_LAT(1),
                     .SYNC_POL(1'b0), .MODE(0)) dut_a (
    .CLK(clk), .RESET(rst), .ENABLE(1'b1), .IN_HS(in_hs), .IN_VS(in_vs), .IN_VISIBLE(in_vis),
    .BRAM_ADDR(a_addr), .BRAM_DOUT(a_dout), .VGA_R(a_r), .VGA_G(a_g), .VGA_B(a_b),
    .VGA_HS(a_hs), .VGA_VS(a_vs));

  // b: 3x3 -> 8x6 grey, latency 3
  vga_scaler_fetch #(.SRC_W(3), .SRC_H(3), .DST_W(8), .DST_H(6), .ADDR_W(8), .BRAM_LAT(3),
                     .SYNC_POL(1'b0), .MODE(0)) dut_b (
    .CLK(clk), .RESET(rst), .ENABLE(1'b1), .IN_HS(in_hs), .IN_VS(in_vs), .IN_VISIBLE(in_vis),
    .BRAM_ADDR(b_addr), .BRAM_DOUT(b_dout), .VGA_R(b_r), .VGA_G(b_g), .VGA_B(b_b),
    .VGA_HS(b_hs), .VGA_VS(b_vs));

  // c: RGB332 with a constant source byte, own enable
  vga_scaler_fetch #(.SRC_W(4), .SRC_H(3), .DST_W(8), .DST_H(6), .ADDR_W(8), .BRAM_LAT(1),
                     .SYNC_POL(1'b0), .MODE(1)) dut_c (
    .CLK(clk), .RESET(rst), .ENABLE(en_c), .IN_HS(in_hs), .IN_VS(in_vs), .IN_VISIBLE(in_vis),
    .BRAM_ADDR(c_addr), .BRAM_DOUT(c_dout), .VGA_R(c_r), .VGA_G(c_g), .VGA_B(c_b),
    .VGA_HS(c_hs), .VGA_VS(c_vs));

  // BRAM models: data = address
  always @(posedge clk) a_dout <= a_addr;
  always @(posedge clk) begin
    b_p0   <= b_addr;
    b_p1   <= b_p0;
    b_dout <= b_p1;
  end
  assign c_dout = 8'b101_110_01;

  int xa  [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 3, 3};
  int rba [8]  = '{0, 0, 4, 4, 8, 8, 8, 8};
  int xb  [10] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 2};
  int rbb [8]  = '{0, 0, 3, 3, 6, 6, 6, 6};

  bit h_hs [HN], h_vs [HN], h_vis [HN], h_rst [HN], h_en [HN], h_known [HN];
  int h_ea [HN], h_eb [HN];
  int k = 0;
  bit known = 1'b0;

  int n_chk = 0, n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @step %0d: got %0d expected %0d", tag, k, got, exp);
  endtask

  task automatic check_out(input string tag, input int lat, input logic hs, input logic vs,
                           input logic [7:0] r, input logic [7:0] g, input logic [7:0] bl,
                           input int which);
    int  j;
    bit  clr;
    bit  act;
    int  byt;
    if (k < lat) return;
    j   = k - lat;
    clr = 1'b0;
    for (int i = j; i < k; i++) if (h_rst[i]) clr = 1'b1;
    if (clr) begin
      check({tag, "_rst_hs"}, hs, 1);
      check({tag, "_rst_vs"}, vs, 1);
      check({tag, "_rst_rgb"}, {r, g, bl}, 0);
      return;
    end
    check({tag, "_hs"}, hs, h_hs[j]);
    check({tag, "_vs"}, vs, h_vs[j]);
    act = h_vis[j] && (which != 2 || h_en[j]);
    if (!act) check({tag, "_blank_rgb"}, {r, g, bl}, 0);
    else if (which == 2) begin
      check({tag, "_r332"}, r, 8'hB6);
      check({tag, "_g332"}, g, 8'hDB);
      check({tag, "_b332"}, bl, 8'h55);
    end else if (h_known[j]) begin
      byt = (which == 0) ? h_ea[j] : h_eb[j];
      check({tag, "_r"}, r, byt);
      check({tag, "_g"}, g, byt);
      check({tag, "_b"}, bl, byt);
    end
  endtask

  task automatic sample_all();
    int j;
    if (k < 1) return;
    j = k - 1;
    if (h_rst[j]) begin
      check("a_rst_addr", a_addr, 0);
      check("b_rst_addr", b_addr, 0);
      check("c_rst_addr", c_addr, 0);
    end else if (!h_vis[j]) begin
      check("a_idle_addr", a_addr, 0);
      check("b_idle_addr", b_addr, 0);
    end else if (h_known[j]) begin
      check("a_addr", a_addr, h_ea[j]);
      check("b_addr", b_addr, h_eb[j]);
    end
    if (!h_rst[j] && !h_en[j]) check("c_dis_addr", c_addr, 0);
    check_out("a", 3, a_hs, a_vs, a_r, a_g, a_b, 0);
    check_out("b", 5, b_hs, b_vs, b_r, b_g, b_b, 1);
    check_out("c", 3, c_hs, c_vs, c_r, c_g, c_b, 2);
  endtask

  task automatic step(input bit hs, input bit vs, input bit vis, input bit r, input bit en,
                      input int ea, input int eb);
    @(negedge clk);
    sample_all();
    if (k >= HN) begin
      $display("FAIL history_overflow: got %0d expected below %0d", k, HN);
      $fatal(1, "history overflow");
    end
    rst = r; in_hs = hs; in_vs = vs; in_vis = vis; en_c = en;
    h_hs[k] = hs; h_vs[k] = vs; h_vis[k] = vis; h_rst[k] = r; h_en[k] = en;
    h_known[k] = known; h_ea[k] = ea; h_eb[k] = eb;
    k++;
  endtask

  task automatic idle(input bit en, input int n);
    repeat (n) step(1'b1, 1'b1, 1'b0, 1'b0, en, 0, 0);
  endtask

  // One frame: VS pulse, then lines of HS pulse, back porch, visible run, front porch.
  task automatic frame(input int lines, input int pix, input int rst_line, input bit en);
    idle(en, 2);
    known = 1'b1;
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, en, 0, 0);
    idle(en, 2);
    for (int y = 0; y < lines; y++) begin
      repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0, en, 0, 0);
      idle(en, 2);
      for (int x = 0; x < pix; x++) begin
        if (y == rst_line && x == 4) begin
          known = 1'b0;
          step(1'b1, 1'b1, 1'b1, 1'b1, en, 0, 0);
        end else begin
          step(1'b1, 1'b1, 1'b1, 1'b0, en, rba[y] + xa[x], rbb[y] + xb[x]);
        end
      end
      idle(en, 2);
    end
  endtask

  initial begin
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0, 0);
    frame(6, 8, -1, 1'b1);
    frame(6, 8, 2, 1'b1);
    frame(6, 8, -1, 1'b1);
    frame(8, 10, -1, 1'b1);
    frame(6, 8, -1, 1'b1);
    frame(6, 8, -1, 1'b0);
    frame(6, 8, -1, 1'b1);
    idle(1'b1, 6);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
